// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state and display encodings for the faregate controller
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OPEN,
    DENY
  } state_e;

  typedef enum logic [1:0] {
    DISP_READY    = 2'b00,
    DISP_OK       = 2'b01,
    DISP_INACTIVE = 2'b10,
    DISP_NOFUNDS  = 2'b11
  } disp_e;

endpackage

// File: rtl/fsm_edge_det.sv
// rtl/fsm_edge_det.sv - 1-bit rising-edge detector; a held input fires once
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/fsm.sv
// rtl/fsm.sv - faregate controller: tap, card check, timed open or denial display
module fsm
  import fsm_pkg::*;
#(
  parameter int OPEN_CYCLES = 3,
  parameter int DENY_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nfc,
  input  logic       card_active,
  input  logic       fund_enough,
  output logic       open,
  output logic       reduce_bal,
  output logic [1:0] disp
);

  localparam int MAX_CYCLES = (OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  state_e        state;
  logic [TW-1:0] timer;
  logic          tap;

  edge_det u_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (nfc),
    .rise (tap)
  );

  // Outputs are assigned alongside the state transition so they reflect the
  // state being entered, with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      open       <= 1'b0;
      reduce_bal <= 1'b0;
      disp       <= DISP_READY;
    end else begin
      reduce_bal <= 1'b0;
      case (state)
        IDLE: begin
          if (tap) state <= CHECK;
        end
        CHECK: begin
          if (!card_active) begin
            state <= DENY;
            disp  <= DISP_INACTIVE;
            timer <= TW'(DENY_CYCLES);
          end else if (!fund_enough) begin
            state <= DENY;
            disp  <= DISP_NOFUNDS;
            timer <= TW'(DENY_CYCLES);
          end else begin
            state      <= OPEN;
            open       <= 1'b1;
            reduce_bal <= 1'b1;
            disp       <= DISP_OK;
            timer      <= TW'(OPEN_CYCLES);
          end
        end
        OPEN, DENY: begin
          if (timer == TW'(1)) begin
            state <= IDLE;
            open  <= 1'b0;
            disp  <= DISP_READY;
            timer <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm.sv
// tb/tb_fsm.sv - scoreboard bench for the faregate controller
module tb_fsm;

  localparam int OPEN_CYCLES = 3;
  localparam int DENY_CYCLES = 3;

  typedef struct {
    logic       open;
    logic       red;
    logic [1:0] disp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nfc = 1'b0;
  logic       card_active = 1'b0;
  logic       fund_enough = 1'b0;
  logic       open;
  logic       reduce_bal;
  logic [1:0] disp;

  fsm #(.OPEN_CYCLES(OPEN_CYCLES), .DENY_CYCLES(DENY_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nfc        (nfc),
    .card_active(card_active),
    .fund_enough(fund_enough),
    .open       (open),
    .reduce_bal (reduce_bal),
    .disp       (disp)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   dut_debits = 0;
  int   model_debits = 0;
  logic in_reset = 1'b1;
  exp_t exp_q[$];

  // Reference model: a transaction is a scheduled list of expected outputs.
  exp_t plan[$];
  logic pending_check = 1'b0;
  logic prev_nfc = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got open/red/disp=%b required %b", name, $time, act, exp);
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.open = 1'b0; e.red = 1'b0; e.disp = 2'b00;
    return e;
  endfunction

  task automatic model_edge();
    exp_t e;
    if (pending_check) begin
      pending_check = 1'b0;
      if (card_active && fund_enough) begin
        for (int i = 0; i < OPEN_CYCLES; i++) begin
          e.open = 1'b1; e.red = (i == 0); e.disp = 2'b01;
          plan.push_back(e);
        end
        model_debits++;
      end else begin
        for (int i = 0; i < DENY_CYCLES; i++) begin
          e.open = 1'b0; e.red = 1'b0; e.disp = card_active ? 2'b11 : 2'b10;
          plan.push_back(e);
        end
      end
      plan.push_back(idle_exp());
      e = plan.pop_front();
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
    end else begin
      if (nfc && !prev_nfc) pending_check = 1'b1;
      e = idle_exp();
    end
    prev_nfc = nfc;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic n, input logic ca, input logic fe);
    nfc = n; card_active = ca; fund_enough = fe;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic tap(input logic ca, input logic fe);
    step(1'b1, 1'($urandom), 1'($urandom));
    step(1'b0, ca, fe);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!in_reset) begin
      if (reduce_bal) dut_debits++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {open, reduce_bal, disp}, {e.open, e.red, e.disp});
      end
    end
  end

  initial begin
    #2;
    check("reset_state", {open, reduce_bal, disp}, 4'b0000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    in_reset = 1'b0;

    // approved, then a second approval seven cycles after the first tap
    tap(1'b1, 1'b1); idle_steps(5);
    tap(1'b1, 1'b1); idle_steps(5);
    // inactive card, with and without funds; insufficient funds
    tap(1'b0, 1'b1); idle_steps(5);
    tap(1'b0, 1'b0); idle_steps(5);
    tap(1'b1, 1'b0); idle_steps(5);
    // card held high for 10 cycles
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
    idle_steps(6);
    // re-tap during OPEN
    tap(1'b1, 1'b1); step(1'b1, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1); idle_steps(5);

    // reset asserted mid-OPEN
    tap(1'b1, 1'b1); step(1'b0, 1'b0, 1'b0);
    #1;
    in_reset = 1'b1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("reset_mid_open", {open, reduce_bal, disp}, 4'b0000);
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", {open, reduce_bal, disp}, 4'b0000);
    plan.delete();
    pending_check = 1'b0;
    prev_nfc = 1'b0;
    nfc = 1'b0;
    rst_n = 1'b1;
    in_reset = 1'b0;
    idle_steps(3);
    tap(1'b1, 1'b1); idle_steps(5);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) == 0, 1'($urandom), 1'($urandom));
    idle_steps(8);
    @(negedge clk); #1;

    check("debit_count", 4'(dut_debits), 4'(model_debits));
    if (dut_debits != model_debits)
      $display("FAIL debit_total: got %0d required %0d", dut_debits, model_debits);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
